// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, condition-flag bit positions and
// flag-unit state encoding. Used by flag_unit, flag_mask_decode and the hazard unit.
package cpu_pkg;

  // Opcodes that touch the condition flags
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  // Bit positions on the flag bus F = {N, V, Z}
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 2;

  // Flag-unit state encoding
  localparam logic ST_RUN    = 1'b0;
  localparam logic ST_HALTED = 1'b1;

endpackage

// File: rtl/flag_mask_decode.sv
// Maps an opcode to the set of condition flags that instruction writes.
// Ports:
//   opcode : 4-bit instruction opcode
//   mask   : 3-bit update mask, bit positions FLAG_Z/FLAG_V/FLAG_N
module flag_mask_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] mask
);

  always_comb begin
    mask = 3'b000;
    case (opcode)
      OP_ADD, OP_SUB: begin
        mask[FLAG_N] = 1'b1;
        mask[FLAG_V] = 1'b1;
        mask[FLAG_Z] = 1'b1;
      end
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: mask[FLAG_Z] = 1'b1;
      default: mask = 3'b000;
    endcase
  end

endmodule

// File: rtl/flag_unit.sv
// Condition-flag producer. Captures ALU results at the end of EX, merges them
// under the per-opcode update mask, holds across stalls, ignores flushed
// instructions and freezes after HLT retires.
// Ports:
//   clk, rst_n  : clock (rising edge), async active-low reset
//   ex_valid    : EX holds a real instruction
//   ex_opcode   : EX opcode
//   alu_result  : ALU output, alu_ovfl: signed overflow
//   stall/flush : EX does not retire / is squashed this cycle
//   halt        : HLT retiring in EX this cycle
//   F           : registered flags {N,V,Z}
//   F_byp       : flags after this cycle's update (same-cycle bypass)
//   halted      : unit is frozen
//   upd_count   : saturating count of committed flag updates
module flag_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [3:0]       ex_opcode,
  input  logic [DW-1:0]    alu_result,
  input  logic             alu_ovfl,
  input  logic             stall,
  input  logic             flush,
  input  logic             halt,
  output logic [2:0]       F,
  output logic [2:0]       F_byp,
  output logic             halted,
  output logic [CNT_W-1:0] upd_count
);

  logic [2:0]       mask;
  logic [2:0]       new_flags;
  logic [2:0]       merged;
  logic             retire;
  logic             commit;
  logic             do_upd;
  logic [2:0]       f_q, f_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             state_q, state_d;

  flag_mask_decode u_mask_decode (
    .opcode (ex_opcode),
    .mask   (mask)
  );

  // retire: the EX instruction actually leaves EX this cycle
  assign retire = ex_valid & ~stall & ~flush;
  assign commit = retire & (state_q == ST_RUN);
  assign do_upd = commit & (|mask);

  always_comb begin
    new_flags         = 3'b000;
    new_flags[FLAG_Z] = (alu_result == '0);
    new_flags[FLAG_V] = alu_ovfl;
    new_flags[FLAG_N] = alu_result[DW-1];
  end

  assign merged = (new_flags & mask) | (f_q & ~mask);

  always_comb begin
    f_d     = f_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    if (do_upd) begin
      f_d = merged;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end
    // A flag-setting HLT still commits its own update above
    if ((state_q == ST_RUN) && retire && halt) state_d = ST_HALTED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q     <= 3'b000;
      cnt_q   <= '0;
      state_q <= ST_RUN;
    end else begin
      f_q     <= f_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign F         = f_q;
  assign F_byp     = f_d;
  assign halted    = (state_q == ST_HALTED);
  assign upd_count = cnt_q;

endmodule

// File: tb/tb_flag_unit.sv
module tb_flag_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] alu_result;
  logic        alu_ovfl;
  logic        stall;
  logic        flush;
  logic        halt;
  logic [2:0]  F;
  logic [2:0]  F_byp;
  logic        halted;
  logic [7:0]  upd_count;

  int passed = 0;
  int total  = 0;

  flag_unit #(.DW(16), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_opcode  (ex_opcode),
    .alu_result (alu_result),
    .alu_ovfl   (alu_ovfl),
    .stall      (stall),
    .flush      (flush),
    .halt       (halt),
    .F          (F),
    .F_byp      (F_byp),
    .halted     (halted),
    .upd_count  (upd_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        v;
    logic [3:0]  op;
    logic [15:0] res;
    logic        ov, st, fl, hl;
    logic [2:0]  byp;
    logic [2:0]  f;
    logic        h;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                       input logic ov, input logic st, input logic fl, input logic hl);
    ex_valid = v; ex_opcode = op; alu_result = res;
    alu_ovfl = ov; stall = st; flush = fl; halt = hl;
  endtask

  task automatic add(input string n, input logic v, input logic [3:0] op,
                     input logic [15:0] res, input logic ov, input logic st,
                     input logic fl, input logic hl, input logic [2:0] byp,
                     input logic [2:0] f, input logic h, input logic [7:0] cnt);
    vec_t x;
    x.name = n; x.v = v; x.op = op; x.res = res; x.ov = ov; x.st = st;
    x.fl = fl; x.hl = hl; x.byp = byp; x.f = f; x.h = h; x.cnt = cnt;
    vecs.push_back(x);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    //  name          v  op     result    ov st fl hl  byp     F       h  cnt
    add("add_zero",   1, 4'h0, 16'h0000, 1, 0, 0, 0, 3'b011, 3'b011, 0, 8'd1);
    add("sub_neg",    1, 4'h1, 16'h8000, 0, 0, 0, 0, 3'b100, 3'b100, 0, 8'd2);
    add("xor_nz",     1, 4'h2, 16'h1234, 0, 0, 0, 0, 3'b100, 3'b100, 0, 8'd3);
    add("stall1",     1, 4'h0, 16'h0000, 0, 1, 0, 0, 3'b100, 3'b100, 0, 8'd3);
    add("stall2",     1, 4'h0, 16'h0000, 0, 1, 0, 0, 3'b100, 3'b100, 0, 8'd3);
    add("stall3",     1, 4'h0, 16'h0000, 0, 1, 0, 0, 3'b100, 3'b100, 0, 8'd3);
    add("stall_rel",  1, 4'h0, 16'h0000, 0, 0, 0, 0, 3'b001, 3'b001, 0, 8'd4);
    add("xor_clrz",   1, 4'h2, 16'h0005, 0, 0, 0, 0, 3'b000, 3'b000, 0, 8'd5);
    add("sll_flush",  1, 4'h4, 16'h0000, 0, 0, 1, 0, 3'b000, 3'b000, 0, 8'd5);
    add("hlt_flush",  1, 4'h4, 16'h0000, 0, 0, 1, 1, 3'b000, 3'b000, 0, 8'd5);
    add("nomask_op",  1, 4'h3, 16'h0000, 1, 0, 0, 0, 3'b000, 3'b000, 0, 8'd5);
    add("invalid",    0, 4'h0, 16'h0000, 1, 0, 0, 0, 3'b000, 3'b000, 0, 8'd5);
    add("sra_zero",   1, 4'h5, 16'h0000, 0, 0, 0, 0, 3'b001, 3'b001, 0, 8'd6);
    add("ror_nz",     1, 4'h6, 16'h8000, 1, 0, 0, 0, 3'b000, 3'b000, 0, 8'd7);
    add("sll_zero",   1, 4'h4, 16'h0000, 0, 0, 0, 0, 3'b001, 3'b001, 0, 8'd8);
    add("hlt_stall",  1, 4'h0, 16'hFFFF, 0, 1, 0, 1, 3'b001, 3'b001, 0, 8'd8);
    add("add_halt",   1, 4'h0, 16'hFFFF, 0, 0, 0, 1, 3'b100, 3'b100, 1, 8'd9);
    add("sub_halted", 1, 4'h1, 16'h0000, 0, 0, 0, 0, 3'b100, 3'b100, 1, 8'd9);

    // Reset state
    #12;
    chk("rst_F", 32'(F), 32'h0);
    chk("rst_byp", 32'(F_byp), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_cnt", 32'(upd_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].op, vecs[i].res, vecs[i].ov, vecs[i].st, vecs[i].fl,
            vecs[i].hl);
      #1;
      chk({vecs[i].name, "_byp"}, 32'(F_byp), 32'(vecs[i].byp));
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_F"}, 32'(F), 32'(vecs[i].f));
      chk({vecs[i].name, "_halted"}, 32'(halted), 32'(vecs[i].h));
      chk({vecs[i].name, "_cnt"}, 32'(upd_count), 32'(vecs[i].cnt));
    end

    // Reset while HALTED takes effect immediately
    @(negedge clk);
    drive(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rsthalt_F", 32'(F), 32'h0);
    chk("rsthalt_halted", 32'(halted), 32'h0);
    chk("rsthalt_cnt", 32'(upd_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Set flags, then reset in the middle of a stall
    @(negedge clk);
    drive(1'b1, 4'h1, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_stall_F", 32'(F), 32'h6);
    @(negedge clk);
    drive(1'b1, 4'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("mid_stall_F", 32'(F), 32'h6);
    rst_n = 1'b0;
    #1;
    chk("rststall_F", 32'(F), 32'h0);
    chk("rststall_cnt", 32'(upd_count), 32'h0);
    @(negedge clk);
    drive(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Saturation of the update counter
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      drive(1'b1, 4'h0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
      if (k == 254) begin
        @(posedge clk);
        #1;
        chk("cnt_255", 32'(upd_count), 32'hFF);
      end
    end
    @(posedge clk);
    #1;
    chk("sat_cnt", 32'(upd_count), 32'hFF);
    chk("sat_F", 32'(F), 32'h0);
    @(negedge clk);
    drive(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("sat_hold", 32'(upd_count), 32'hFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
